// File: rtl/uart_word_sender.sv
// Serializes a WIDTH-bit word into bytes for uart_transmit, one trigger pulse per byte,
// pacing each byte on the transmitter's busy flag.
module uart_word_sender #(
  parameter int WIDTH     = 256,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [7:0]       data_byte_out,
  output logic             trigger_out,
  input  logic             busy_in,
  output logic             busy_out,
  output logic             done_out
);

  localparam int NUM_BYTES = WIDTH / 8;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GUARD, S_WAIT} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next;
  logic [CW-1:0]    r_count, w_count_next;
  logic [7:0]       r_byte, w_byte_next;
  logic             r_trigger, w_trigger_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_ready, w_ready_next;

  logic [7:0]       w_cur_byte;
  logic [WIDTH-1:0] w_shifted;

  // The byte in flight always sits at the outgoing end of the shift register.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_cur_byte = r_shreg[WIDTH-1 -: 8];
      assign w_shifted  = r_shreg << 8;
    end else begin : g_lsb
      assign w_cur_byte = r_shreg[7:0];
      assign w_shifted  = r_shreg >> 8;
    end
  endgenerate

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_count_next   = r_count;
    w_byte_next    = r_byte;
    w_trigger_next = 1'b0;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_shreg_next = data_in;
          w_count_next = '0;
          w_busy_next  = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!busy_in) begin
          w_byte_next    = w_cur_byte;
          w_trigger_next = 1'b1;
          w_state_next   = S_GUARD;
        end
      end
      // The transmitter raises busy one cycle after trigger; skip that blind cycle.
      S_GUARD: w_state_next = S_WAIT;
      S_WAIT: begin
        if (!busy_in) begin
          if (r_count == LAST_COUNT) begin
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
          end else begin
            w_count_next = r_count + 1'b1;
            w_shreg_next = w_shifted;
            w_state_next = S_LOAD;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    w_ready_next = (w_state_next == S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_count   <= '0;
      r_byte    <= '0;
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_count   <= w_count_next;
      r_byte    <= w_byte_next;
      r_trigger <= w_trigger_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_ready   <= w_ready_next;
    end
  end

  assign ready_out     = r_ready;
  assign data_byte_out = r_byte;
  assign trigger_out   = r_trigger;
  assign busy_out      = r_busy;
  assign done_out      = r_done;

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: three instances (16-bit MSB-first, 16-bit LSB-first, 256-bit
// MSB-first), each driving a transmitter model that stays busy 20 cycles after a trigger.
module tb_uart_word_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [2:0][255:0]     d;
  logic [2:0]            v, ready, trig, bsy_o, done, bsy_i, ext_busy;
  logic [2:0][7:0]       byt;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int done_cnt[3];
  logic [2:0] prev_trig = '0;
  int dbl_trig = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int W   = (gi == 2) ? 256 : 16;
      localparam bit MSB = (gi != 1);
      int mcnt = 0;
      uart_word_sender #(.WIDTH(W), .MSB_FIRST(MSB)) u_dut (
        .clk_in(clk), .rst_in(rst_n), .data_in(d[gi][W-1:0]), .valid_in(v[gi]),
        .ready_out(ready[gi]), .data_byte_out(byt[gi]), .trigger_out(trig[gi]),
        .busy_in(bsy_i[gi]), .busy_out(bsy_o[gi]), .done_out(done[gi]));
      // Transmitter model: busy becomes visible on the edge that samples trigger.
      always @(posedge clk) begin
        if (trig[gi] === 1'b1) mcnt <= 20;
        else if (mcnt != 0)    mcnt <= mcnt - 1;
      end
      assign bsy_i[gi] = ext_busy[gi] | (mcnt != 0);
    end
  endgenerate

  // Advance one cycle and record what the DUTs produced on that edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (trig[i] === 1'b1) begin
        obs_q.push_back({8'(i), byt[i]});
        if (prev_trig[i]) dbl_trig++;
      end
      prev_trig[i] = (trig[i] === 1'b1);
      if (done[i] === 1'b1) done_cnt[i]++;
    end
  endtask

  task automatic send(input int i, input logic [255:0] w, input int nb, input bit msb,
                      input bit keep, output bit ok);
    logic rdy;
    ok = 1'b0;
    d[i] = w;
    v[i] = 1'b1;
    for (int j = 0; j < nb; j++)
      exp_q.push_back({8'(i), msb ? w[8*(nb-1-j) +: 8] : w[8*j +: 8]});
    for (int k = 0; k < 3000 && !ok; k++) begin
      rdy = ready[i];
      step();
      ok = (rdy === 1'b1);
    end
    if (!keep) v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int target, output int cycles);
    cycles = 0;
    while (done_cnt[i] < target && cycles < 5000) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v = '0;
    d = '0;
    ext_busy = '0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      vectors += 5;
      if (ready[i] !== 1'b1) begin miscompares++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, ready[i]); end
      if (bsy_o[i] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, bsy_o[i]); end
      if (trig[i] !== 1'b0)  begin miscompares++; $display("FAIL reset_trigger[%0d]: got %b expected 0", i, trig[i]); end
      if (done[i] !== 1'b0)  begin miscompares++; $display("FAIL reset_done[%0d]: got %b expected 0", i, done[i]); end
      if (byt[i] !== 8'h00)  begin miscompares++; $display("FAIL reset_byte[%0d]: got %h expected 00", i, byt[i]); end
    end
    rst_n = 1'b1;
    obs_q.delete();
    step();
  endtask

  task automatic test_msb16();
    bit ok;
    int cyc;
    int base = done_cnt[0];
    logic [15:0] e, o;
    send(0, 256'h1E6B, 2, 1'b1, 1'b0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL msb16_accept: got timeout expected accept"); end
    vectors++;
    if (trig[0] !== 1'b0) begin miscompares++; $display("FAIL msb16_early_trigger: got %b expected 0", trig[0]); end
    step();
    vectors++;
    if (trig[0] !== 1'b1 || byt[0] !== 8'h1E) begin
      miscompares++; $display("FAIL msb16_latency: got trig=%b byte=%h expected trig=1 byte=1e", trig[0], byt[0]);
    end
    wait_done(0, base + 1, cyc);
    vectors++;
    if (cyc + 1 != 46) begin miscompares++; $display("FAIL msb16_done_time: got %0d expected 46", cyc + 1); end
    repeat (5) step();
    vectors += 3;
    if (done_cnt[0] !== base + 1) begin miscompares++; $display("FAIL msb16_done_pulses: got %0d expected %0d", done_cnt[0] - base, 1); end
    if (ready[0] !== 1'b1) begin miscompares++; $display("FAIL msb16_ready_after: got %b expected 1", ready[0]); end
    if (bsy_o[0] !== 1'b0) begin miscompares++; $display("FAIL msb16_busy_after: got %b expected 0", bsy_o[0]); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL msb16_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL msb16_byte: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_lsb16();
    bit ok;
    int cyc;
    int base = done_cnt[1];
    logic [15:0] e, o;
    send(1, 256'h1E6B, 2, 1'b0, 1'b0, ok);
    wait_done(1, base + 1, cyc);
    repeat (3) step();
    vectors += 2;
    if (!ok || cyc != 46) begin miscompares++; $display("FAIL lsb16_done_time: got %0d expected 46", cyc); end
    if (done_cnt[1] !== base + 1) begin miscompares++; $display("FAIL lsb16_done_pulses: got %0d expected 1", done_cnt[1] - base); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL lsb16_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL lsb16_byte: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_busy_hold();
    bit ok;
    int cyc;
    int base = done_cnt[0];
    logic [15:0] e, o;
    ext_busy[0] = 1'b1;
    send(0, 256'h1E6B, 2, 1'b1, 1'b0, ok);
    for (int k = 0; k < 50; k++) begin
      v[0] = (k % 7 == 3);
      d[0] = 256'($urandom);
      step();
      vectors++;
      if (ready[0] !== 1'b0) begin miscompares++; $display("FAIL hold_ready: got %b expected 0 at cycle %0d", ready[0], k); end
    end
    v[0] = 1'b0;
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL hold_no_trigger: got %0d triggers expected 0", obs_q.size()); end
    ext_busy[0] = 1'b0;
    wait_done(0, base + 1, cyc);
    repeat (5) step();
    vectors++;
    if (!ok || done_cnt[0] !== base + 1) begin miscompares++; $display("FAIL hold_done: got %0d expected 1", done_cnt[0] - base); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL hold_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL hold_byte: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_w256();
    bit ok;
    int cyc;
    int base = done_cnt[2];
    logic [255:0] w;
    logic [15:0] e, o;
    for (int j = 0; j < 32; j++) w[8*(31-j) +: 8] = 8'(j);
    send(2, w, 32, 1'b1, 1'b0, ok);
    wait_done(2, base + 1, cyc);
    repeat (3) step();
    vectors += 2;
    if (!ok || cyc != 736) begin miscompares++; $display("FAIL w256_done_time: got %0d expected 736", cyc); end
    if (done_cnt[2] !== base + 1) begin miscompares++; $display("FAIL w256_done_pulses: got %0d expected 1", done_cnt[2] - base); end
    vectors++;
    if (obs_q.size() != 32) begin miscompares++; $display("FAIL w256_count: got %0d expected 32", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL w256_byte: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    int base = done_cnt[2];
    logic [255:0] w;
    logic [15:0] e, o;
    for (int j = 0; j < 32; j++) w[8*(31-j) +: 8] = 8'(j + 8'h40);
    send(2, w, 32, 1'b1, 1'b0, ok);
    cyc = 0;
    while (obs_q.size() < 3 && cyc < 500) begin step(); cyc++; end
    vectors++;
    if (obs_q.size() != 3) begin miscompares++; $display("FAIL rmid_third_byte: got %0d bytes expected 3", obs_q.size()); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors += 3;
    if (ready[2] !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b expected 1", ready[2]); end
    if (bsy_o[2] !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b expected 0", bsy_o[2]); end
    if (trig[2] !== 1'b0)  begin miscompares++; $display("FAIL rmid_trigger: got %b expected 0", trig[2]); end
    repeat (60) step();
    vectors++;
    if (obs_q.size() != 3) begin miscompares++; $display("FAIL rmid_no_more: got %0d bytes expected 3", obs_q.size()); end
    for (int j = 0; j < 3 && obs_q.size() > 0; j++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rmid_partial_byte: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    send(2, {32{8'hA5}}, 32, 1'b1, 1'b0, ok);
    wait_done(2, base + 1, cyc);
    repeat (3) step();
    vectors += 2;
    if (!ok || done_cnt[2] !== base + 1) begin miscompares++; $display("FAIL rmid_done: got %0d expected 1", done_cnt[2] - base); end
    if (obs_q.size() != 32) begin miscompares++; $display("FAIL rmid_count: got %0d expected 32", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rmid_byte: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    int base = done_cnt[0];
    logic [15:0] e, o;
    send(0, 256'h1234, 2, 1'b1, 1'b1, ok);
    d[0] = 256'hABCD;
    exp_q.push_back({8'd0, 8'hAB});
    exp_q.push_back({8'd0, 8'hCD});
    wait_done(0, base + 1, cyc);
    vectors++;
    if (ready[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_with_done: got %b expected 1", ready[0]); end
    step();
    v[0] = 1'b0;
    vectors++;
    if (bsy_o[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_second_accept: got busy=%b expected 1", bsy_o[0]); end
    wait_done(0, base + 2, cyc);
    repeat (5) step();
    vectors++;
    if (!ok || done_cnt[0] !== base + 2) begin miscompares++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt[0] - base); end
    vectors++;
    if (obs_q.size() != 4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL b2b_byte: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_protocol();
    vectors++;
    if (dbl_trig != 0) begin miscompares++; $display("FAIL trigger_width: got %0d double pulses expected 0", dbl_trig); end
  endtask

  initial begin
    test_reset();
    test_msb16();
    test_lsb16();
    test_busy_hold();
    test_w256();
    test_reset_mid();
    test_back_to_back();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
